// File: rtl/box_plotter_pkg.sv
// Shared constants and state encoding for the box_plotter sprite stage.
// The optional power-on screen sweep is enabled with BOX_PLOTTER_CLEAR_EN.
package box_plotter_pkg;

    localparam logic [8:0] SCREEN_W     = 9'd160;
    localparam logic [7:0] SCREEN_H     = 8'd120;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam int unsigned CLEAR_LEN   = 160 * 120;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/box_plotter_scan_counter.sv
// Offset counter that walks every pixel of the box in row-major order.
// off_nxt exposes the value the counter will hold after the coming edge.
module box_scan_counter
    import box_plotter_pkg::*;
#(
    parameter int BOX_BITS = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  en,
    output logic [2*BOX_BITS-1:0] off_nxt,
    output logic                  last
);

    localparam int OFF_W = 2 * BOX_BITS;

    logic [OFF_W-1:0] off_q;
    logic [OFF_W-1:0] off_d;

    always_comb begin
        off_d = off_q;
        if (clr) begin
            off_d = '0;
        end else if (en) begin
            off_d = off_q + OFF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign off_nxt = off_d;
    assign last    = &off_q;

endmodule

// File: rtl/box_plotter.sv
// Erase-then-draw box sprite plotter feeding vga_adapter one pixel per clock.
// Define BOX_PLOTTER_CLEAR_EN to sweep the whole screen black after reset.
module box_plotter
    import box_plotter_pkg::*;
#(
    parameter int BOX_BITS = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       move,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int OFF_W = 2 * BOX_BITS;

    state_t     state_q, state_d;
    logic       old_valid_q, old_valid_d;
    logic [7:0] old_x_q, old_x_d, new_x_q, new_x_d;
    logic [6:0] old_y_q, old_y_d, new_y_q, new_y_d;
    logic [2:0] new_colour_q, new_colour_d;

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic             cnt_clr, cnt_en, cnt_last;
    logic [OFF_W-1:0] off_nxt;
    logic [7:0]       base_x;
    logic [6:0]       base_y;
    logic [2:0]       pix_colour;
    logic [8:0]       px;
    logic [7:0]       py;

`ifdef BOX_PLOTTER_CLEAR_EN
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
`endif

    box_scan_counter #(.BOX_BITS(BOX_BITS)) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .off_nxt (off_nxt),
        .last    (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        old_valid_d  = old_valid_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        new_colour_d = new_colour_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        x_d          = '0;
        y_d          = '0;
        colour_d     = '0;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef BOX_PLOTTER_CLEAR_EN
        cx_d         = cx_q;
        cy_d         = cy_q;
`endif

        case (state_q)
            ST_CLEAR: begin
`ifdef BOX_PLOTTER_CLEAR_EN
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = COLOUR_BLACK;
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                if (cx_q == 8'(SCREEN_W - 9'd1)) begin
                    cx_d = '0;
                    if (cy_q == 7'(SCREEN_H - 8'd1)) begin
                        cy_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (move) begin
                    new_x_d      = x_in;
                    new_y_d      = y_in;
                    new_colour_d = colour_in;
                    cnt_clr      = 1'b1;
                    state_d      = old_valid_q ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    old_x_d     = new_x_q;
                    old_y_d     = new_y_q;
                    old_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so each pixel lines up with its state cycle.
        base_x     = old_x_q;
        base_y     = old_y_q;
        pix_colour = COLOUR_BLACK;
        if (state_d == ST_DRAW) begin
            base_x     = new_x_d;
            base_y     = new_y_d;
            pix_colour = new_colour_d;
        end
        px = {1'b0, base_x} + 9'(off_nxt[BOX_BITS-1:0]);
        py = {1'b0, base_y} + 8'(off_nxt[OFF_W-1:BOX_BITS]);

        if (state_d == ST_ERASE || state_d == ST_DRAW) begin
            x_d      = px[7:0];
            y_d      = py[6:0];
            colour_d = pix_colour;
            plot_d   = (px < SCREEN_W) && (py < SCREEN_H);
            busy_d   = 1'b1;
        end
        if (state_d == ST_DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
`ifdef BOX_PLOTTER_CLEAR_EN
            state_q <= ST_CLEAR;
            cx_q    <= '0;
            cy_q    <= '0;
`else
            state_q <= ST_IDLE;
`endif
            old_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
`ifdef BOX_PLOTTER_CLEAR_EN
            cx_q <= cx_d;
            cy_q <= cy_d;
`endif
            state_q     <= state_d;
            old_valid_q <= old_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Position registers carry no reset; old_valid_q qualifies their contents.
    always_ff @(posedge clk) begin
        old_x_q      <= old_x_d;
        old_y_q      <= old_y_d;
        new_x_q      <= new_x_d;
        new_y_q      <= new_y_d;
        new_colour_q <= new_colour_d;
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_box_plotter.sv
// Scoreboard bench for box_plotter: a box-level model queues expected pixels and done cycles.
module tb_box_plotter;

    localparam int BB   = 2;
    localparam int SIDE = 1 << BB;
    localparam int NPIX = SIDE * SIDE;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       move = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    box_plotter #(.BOX_BITS(BB)) dut (
        .clk(clk), .resetn(resetn), .move(move), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .busy(busy), .done(done), .x(x), .y(y),
        .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int px; int py; int pc; int pcyc; } pix_t;
    pix_t exp_q[$];
    int   done_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    bit m_valid = 1'b0;
    int m_ox = 0, m_oy = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference box: every on-screen pixel of a SIDE x SIDE square, row-major.
    task automatic push_box(input int bx, input int by, input int col, input int start);
        for (int dy = 0; dy < SIDE; dy++)
            for (int dx = 0; dx < SIDE; dx++)
                if (bx + dx < 160 && by + dy < 120)
                    exp_q.push_back('{bx + dx, by + dy, col, start + dy * SIDE + dx});
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_colour"}, int'(colour), 0);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic clear_sweep(input int r);
`ifdef BOX_PLOTTER_CLEAR_EN
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                exp_q.push_back('{xx, yy, 0, r + 1 + yy * 160 + xx});
        while (cyc < r + 19201) begin
            move = (cyc == r + 100);
            x_in = 8'd5;
            @(posedge clk); #1;
        end
        move = 1'b0;
        chk("clear_end_busy", int'(busy), 0);
`else
        chk("no_clear_busy", int'(busy), 0);
`endif
    endtask

    task automatic do_move(input int bx, input int by, input int col,
                           input int s1, input int s2, input int rst_at);
        int c0, len, k;
        @(posedge clk); #1;
        x_in = 8'(bx); y_in = 7'(by); colour_in = 3'(col); move = 1'b1;
        c0 = cyc;
        len = m_valid ? 2 * NPIX : NPIX;
        if (m_valid) push_box(m_ox, m_oy, 0, c0 + 1);
        push_box(bx, by, col, c0 + 1 + len - NPIX);
        done_q.push_back(c0 + len + 1);
        m_valid = 1'b1; m_ox = bx; m_oy = by;
        while (1) begin
            @(posedge clk); #1;
            k = cyc - c0;
            move = 1'b0;
            if (k == 1) chk("busy_after_accept", int'(busy), 1);
            if (rst_at > 0 && k == rst_at + 1) begin
                exp_q.delete();
                done_q.delete();
                chk_zero_outputs("mid_reset");
                resetn = 1'b1;
                m_valid = 1'b0;
                clear_sweep(cyc);
                return;
            end
            if (k > len + 1) break;
            if (k == s1 || k == s2) begin
                move = 1'b1;
                x_in = 8'($urandom_range(0, 150));
                y_in = 7'($urandom_range(0, 110));
                colour_in = 3'($urandom_range(0, 7));
            end
            if (rst_at > 0 && k == rst_at) resetn = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (plot) begin
                chk("plot_implies_busy", int'(busy), 1);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_plot: got (%0d,%0d) c%0d expected none (cycle %0d)",
                             x, y, colour, cyc);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (int'(x) != e.px || int'(y) != e.py || int'(colour) != e.pc || cyc != e.pcyc) begin
                        n_bad++;
                        $display("FAIL pixel: got (%0d,%0d) c%0d @%0d expected (%0d,%0d) c%0d @%0d",
                                 x, y, colour, cyc, e.px, e.py, e.pc, e.pcyc);
                    end
                end
            end
            if (done) begin
                chk("done_busy_low", int'(busy), 0);
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin
        int r, bx, by;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        resetn = 1'b1;
        mon_en = 1'b1;
        r = cyc;
        clear_sweep(r);

        do_move(10, 20, 3'b100, 0, 0, 0);
        do_move(11, 20, 3'b010, 0, 0, 0);
        do_move(158, 118, 3'b111, 0, 0, 0);
        do_move(40, 50, 3'b001, 5, 33, 0);
        do_move(70, 60, 3'b011, 0, 0, 20);
        do_move(80, 90, 3'b101, 0, 0, 0);
        do_move(0, 0, 3'b000, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bx = $urandom_range(150, 170);
                by = $urandom_range(110, 127);
            end else begin
                bx = $urandom_range(0, 165);
                by = $urandom_range(0, 125);
            end
            do_move(bx, by, $urandom_range(0, 7),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(1, 33) : 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("pixels_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/box_plotter.md
# box_plotter

Sprite plotting stage between the bouncing-box motion logic and `vga_adapter` in the 160x120, 3-bit-colour display path. On each move request it erases the box at its previously drawn position, then draws it at the new position, emitting one pixel per clock as `x`/`y`/`colour`/`plot` for direct connection to the adapter. It replaces the free-running 16-cycle offset counter with a handshaked erase/draw sequence, so no trails are left and no frame-rate logic lives in the plotter.

## Interface
- `BOX_BITS`, 2: box side is 2^BOX_BITS pixels; the offset counter is 2*BOX_BITS bits wide.
- `clk`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  reset; one clock; reset is synchronous and active-low.
- `move`  in  1  one-cycle request; accepted only in IDLE.
- `x_in`  in  8  new box top-left x.
- `y_in`  in  7  new box top-left y.
- `colour_in`  in  3  box colour; sampled with `move`.
- `busy`  out  1  high from the cycle after acceptance through the last pixel.
- `done`  out  1  one-cycle pulse after the last draw pixel.
- `x`  out  8  pixel x to adapter.
- `y`  out  7  pixel y to adapter.
- `colour`  out  3  pixel colour to adapter.
- `plot`  out  1  pixel write strobe to adapter.

## Operation
- States: CLEAR (macro only), IDLE, ERASE, DRAW, DONE.
- IDLE: `move`=1 latches `x_in`, `y_in`, `colour_in` into new-position registers, clears the offset counter, and goes to ERASE if `old_valid`=1, else to DRAW.
- ERASE: 2^(2*BOX_BITS) cycles; pixel = (old_x + off[BOX_BITS-1:0], old_y + off[2*BOX_BITS-1:BOX_BITS]), colour 3'b000. At the last offset, the counter wraps to 0 and the state goes to DRAW.
- DRAW: same scan at the new position with the latched colour. At the last offset, old_x/old_y are loaded from the new position, `old_valid` is set to 1, and the state goes to DONE.
- DONE: one cycle, `done`=1, then IDLE.
- Clipping: a pixel with x>159 or y>119 (computed at 9/8 bits, no wrap) drives `plot`=0 but still consumes its cycle. Sequence length is constant.
- `move` outside IDLE (including the DONE cycle) is ignored; there is no queueing.
- Colour 3'b000 in DRAW is legal and produces an invisible box.
- Reset (any state, mid-sequence included): state → IDLE (or CLEAR), `old_valid`=0, offset=0. Outputs: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0.

## Timing
- All outputs are registered; each pixel appears one cycle after its state/offset.
- With `move` at cycle 0 and `old_valid`=1 (BOX_BITS=2):
  - erase pixels in cycles 1–16;
  - draw pixels in cycles 17–32;
  - `busy` is high in cycles 1–32;
  - `done`=1 with `busy`=0 in cycle 33;
  - the earliest next accepted `move` is cycle 34.
- First move after reset (`old_valid`=0): draw pixels in cycles 1–16, `done` in cycle 17.
- `plot` is never high while `busy`=0, except in CLEAR.
- Scan order is row-major: x offset is the fast index.

## Configuration
- `BOX_PLOTTER_CLEAR_EN` defined: after reset, the state is CLEAR.
  - Sweeps x 0..159 (fast) and y 0..119 with colour 0 and `plot`=1: 19200 cycles.
  - `busy`=1 throughout; `move` is ignored.
  - On completion the state goes to IDLE; no `done` pulse is generated.
- Undefined: reset goes directly to IDLE and screen clearing relies on the adapter's background image.

## Structure
- Shared package holds:
  - `SCREEN_W`=160, `SCREEN_H`=120;
  - `COLOUR_BLACK`=3'b000;
  - state enum typedef;
  - clear-sweep length constant.
- One sub-module, `box_scan_counter`:
  - 2*BOX_BITS-bit offset counter with clear/enable;
  - `last` flag at all-ones.
- The FSM, position registers and clip compare stay in `box_plotter`.

## Test plan
- Reset, then `move` with (10,20), colour 3'b100 → 16 plots covering x 10..13, y 20..23, colour 4; `done` in cycle 17; no erase pixels.
- Second `move` to (11,20), colour 3'b010 → 16 black plots at x 10..13, y 20..23, then 16 green plots at x 11..14, y 20..23; `done` in cycle 33.
- `move` to (158,118) → pixels with x≥160 or y≥120 have `plot`=0; exactly 4 plots are issued; `done` still occurs in cycle 17 or 33.
- `move` pulsed in cycles 5 and 33 of an active sequence → both are ignored; no extra pixels.
- `resetn` low in cycle 20 of a sequence → next cycle: all outputs 0, IDLE; the following `move` skips erase.
- With `BOX_PLOTTER_CLEAR_EN`: reset → 19200 black plots ending at (159,119), `busy` high throughout; a `move` during the sweep is ignored.
